order_manager: RTL and testbench
================================

Name: order_manager

Overview:
Consumes the trade-signal stream from tick_pipeline (HOLD/BUY/SELL plus the tick price) and converts it into sized orders. Tracks the net position (FLAT/LONG/SHORT), the entry price and realized PnL. Orders are queued in a small FIFO and leave on a valid/ready stream toward the execution/log side. Sits directly downstream of tick_pipeline.

Parameters:
QTY, 1, unit lot size per position leg (unsigned integer, 1..255)
DEPTH, 4, order FIFO depth (power of 2, >=2)
PNL_W, 48, realized PnL width (signed, Q(PNL_W-16).16)
COOLDOWN, 8, cycles of signal suppression after an accepted order (used only with ORDER_COOLDOWN_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sig_valid  in  1  signal beat present (driven from tick_pipeline out_valid)
sig_code  in  2  0=HOLD, 1=BUY, 3=SELL (2'b11 = -1), 2=illegal
sig_price  in  32  Q16.16 tick price that produced the signal
ord_valid  out  1  order available at FIFO head
ord_ready  in  1  downstream accepts the order
ord_side  out  1  0=BUY, 1=SELL
ord_qty  out  9  order quantity (QTY or 2*QTY)
ord_price  out  32  Q16.16 reference price
position  out  2  0=FLAT, 1=LONG, 3=SHORT
pnl  out  PNL_W  signed realized PnL, Q16.16 fraction
drop_cnt  out  16  signals dropped because the FIFO was full (saturating)
err_cnt  out  16  illegal codes received (saturating)
fifo_level  out  $clog2(DEPTH)+1  entries in the order FIFO

Behaviour:
- Reset (async assert, sync deassert): ord_valid=0, position=FLAT, entry=0, pnl=0, drop_cnt=0, err_cnt=0, fifo_level=0, FIFO emptied. ord_side/qty/price read 0.
- There is no input back-pressure: one signal beat is accepted per cycle whenever sig_valid=1.
- Decision table (state, code -> order, next state):
  - FLAT, BUY -> BUY QTY, next LONG.
  - FLAT, SELL -> SELL QTY, next SHORT.
  - SHORT, BUY -> BUY 2*QTY (cover plus open), next LONG.
  - LONG, SELL -> SELL 2*QTY, next SHORT.
  - LONG, BUY or SHORT, SELL -> no order, no change.
  - Any state, HOLD -> nothing.
  - Code 2 -> nothing; err_cnt increments.
- On every order, entry is set to sig_price.
- FIFO full at the cycle an order is generated:
  - The order is not written, position, entry and pnl are unchanged, and drop_cnt increments.
  - A FIFO pop in the same cycle does NOT free the slot for that cycle (full is evaluated before the pop).
- Latency: signal sampled at edge N. The order is visible at the FIFO head at N+1 if the FIFO was empty. position and pnl update at N+1.
- PnL on a reversal:
  - LONG->SHORT: pnl += (sig_price - entry) * QTY.
  - SHORT->LONG: pnl += (entry - sig_price) * QTY.
  - The difference is computed as signed 33-bit, the product is sign-extended to PNL_W, and the accumulator wraps in two's complement.
- FIFO:
  - Show-ahead: ord_* reflect the head whenever ord_valid=1.
  - A pop happens on ord_valid & ord_ready.
  - Simultaneous push and pop keeps the level constant.
  - The head stays stable while ord_valid=1 and ord_ready=0.
- Both counters saturate at 16'hFFFF.

Optional Feature:
ORDER_COOLDOWN_EN:
- Defined:
  - Each accepted order loads a down-counter with COOLDOWN.
  - While the counter is nonzero, BUY/SELL beats are ignored: no order, no state change, no drop_cnt increment. err_cnt still counts code 2.
  - The counter decrements every cycle.
- Undefined: no counter; every BUY/SELL is evaluated.

Decomposition:
- Package order_pkg: signal codes (SIG_HOLD=0, SIG_BUY=1, SIG_SELL=3), position codes (POS_FLAT/LONG/SHORT), side codes (SIDE_BUY/SELL), and the order-entry width constant (1+9+32 bits).
- Sub-module order_fifo: a synchronous show-ahead FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level.
- order_manager holds the decision logic, the PnL datapath and the counters.

Test Plan:
- Reset values: hold rst_n=0 for 5 cycles with sig_valid toggling -> all outputs 0. Assert rst_n mid-run with 3 orders queued -> ord_valid=0 and fifo_level=0 in the same cycle, position=FLAT.
- Open long: FLAT, BUY at 6553600 (100.0) -> next cycle ord_valid=1, side=0, qty=1, price=6553600, position=1, pnl=0.
- Reversal with profit: from the previous state, SELL at 6684672 (102.0) -> order side=1, qty=2, position=3, pnl=131072 (+2.0). Then BUY at 6619136 (101.0) -> qty=2, pnl=196608 (+3.0).
- Redundant and illegal codes: LONG, then BUY x3 and code 2 x2 -> no orders, position=1, err_cnt=2, drop_cnt=0.
- Back-pressure overflow (DEPTH=4): ord_ready=0, 5 alternating BUY/SELL beats -> fifo_level=4, drop_cnt=1, position matches the 4th order. Release ord_ready -> 4 orders emerge in order, with the head stable while stalled.
- ORDER_COOLDOWN_EN build, COOLDOWN=8: BUY at t, SELL at t+3 -> SELL ignored. SELL at t+10 -> order issued. Non-define build with the same stimulus -> the t+3 SELL is issued.

Source files
------------

// File: rtl/order_pkg.sv
// Shared signal/position/side codes and the packed order entry used by order_manager.
package order_pkg;

   typedef enum logic [1:0] {
      SIG_HOLD = 2'b00,
      SIG_BUY  = 2'b01,
      SIG_ILL  = 2'b10,
      SIG_SELL = 2'b11
   } sig_code_e;

   typedef enum logic [1:0] {
      POS_FLAT  = 2'b00,
      POS_LONG  = 2'b01,
      POS_SHORT = 2'b11
   } pos_e;

   typedef enum logic {
      SIDE_BUY  = 1'b0,
      SIDE_SELL = 1'b1
   } side_e;

   localparam int QTY_W   = 9;
   localparam int PRICE_W = 32;
   localparam int ORD_W   = 1 + QTY_W + PRICE_W;

   typedef struct packed {
      side_e              side;
      logic [QTY_W-1:0]   qty;
      logic [PRICE_W-1:0] price;
   } order_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/order_fifo.sv
// Show-ahead order FIFO: head is presented combinationally, outputs read 0 when empty.
// Full is judged on the current level, so a same-cycle pop never makes room for a push.
module order_fifo #(
   parameter int WIDTH = 42,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

// File: rtl/order_manager.sv
// Turns HOLD/BUY/SELL beats into sized orders, tracks position/entry/realized PnL.
// Optional signal cooldown after each accepted order: define ORDER_COOLDOWN_EN.
module order_manager
   import order_pkg::*;
#(
   parameter int QTY      = 1,
   parameter int DEPTH    = 4,
   parameter int PNL_W    = 48,
   parameter int COOLDOWN = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sig_valid,
   input  logic [1:0]               sig_code,
   input  logic [31:0]              sig_price,
   output logic                     ord_valid,
   input  logic                     ord_ready,
   output logic                     ord_side,
   output logic [8:0]               ord_qty,
   output logic [31:0]              ord_price,
   output logic [1:0]               position,
   output logic signed [PNL_W-1:0]  pnl,
   output logic [15:0]              drop_cnt,
   output logic [15:0]              err_cnt,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   if (QTY < 1 || QTY > 255 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || COOLDOWN < 0)
   begin : g_bad_params
      $error("order_manager: unsupported parameter set");
   end

   localparam int                PROD_W = 33 + 10;
   localparam logic signed [9:0] QTY_S  = 10'(QTY);

   pos_e                     r_pos;
   logic [31:0]              r_entry;
   logic signed [PNL_W-1:0]  r_pnl;
   logic [15:0]              r_drop_cnt;
   logic [15:0]              r_err_cnt;

   logic                     w_buy;
   logic                     w_sell;
   logic                     w_ill;
   logic                     w_block;
   logic                     w_want;
   logic                     w_rev;
   logic                     w_push;
   logic                     w_full;
   logic                     w_empty;
   logic signed [32:0]       w_diff;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [PNL_W-1:0]  w_pnl_delta;
   order_t                   w_ord_in;
   order_t                   w_ord_head;

   assign w_buy  = sig_valid && (sig_code == SIG_BUY);
   assign w_sell = sig_valid && (sig_code == SIG_SELL);
   assign w_ill  = sig_valid && (sig_code == SIG_ILL);

   // An order exists only when the signal moves us to a different position.
   assign w_want = ((w_buy && r_pos != POS_LONG) || (w_sell && r_pos != POS_SHORT)) && !w_block;
   assign w_rev  = (w_buy && r_pos == POS_SHORT) || (w_sell && r_pos == POS_LONG);
   assign w_push = w_want && !w_full;

   assign w_diff = (r_pos == POS_LONG) ?
                   ($signed({1'b0, sig_price}) - $signed({1'b0, r_entry})) :
                   ($signed({1'b0, r_entry}) - $signed({1'b0, sig_price}));
   assign w_prod      = PROD_W'(w_diff) * PROD_W'(QTY_S);
   assign w_pnl_delta = PNL_W'(w_prod);

   assign w_ord_in.side  = w_sell ? SIDE_SELL : SIDE_BUY;
   assign w_ord_in.qty   = w_rev ? QTY_W'(2 * QTY) : QTY_W'(QTY);
   assign w_ord_in.price = sig_price;

`ifdef ORDER_COOLDOWN_EN
   localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   logic [CW-1:0] r_cool;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cool <= '0;
      else if (w_push)
         r_cool <= CW'(COOLDOWN);
      else if (r_cool != '0)
         r_cool <= r_cool - CW'(1);
   end

   assign w_block = (r_cool != '0);
`else
   assign w_block = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos      <= POS_FLAT;
         r_entry    <= '0;
         r_pnl      <= '0;
         r_drop_cnt <= '0;
         r_err_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_pos   <= w_buy ? POS_LONG : POS_SHORT;
            r_entry <= sig_price;
            if (w_rev)
               r_pnl <= r_pnl + w_pnl_delta;
         end
         if (w_want && w_full)
            r_drop_cnt <= sat_inc16(r_drop_cnt);
         if (w_ill)
            r_err_cnt <= sat_inc16(r_err_cnt);
      end
   end

   order_fifo #(
      .WIDTH (ORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_ord_in),
      .i_pop   (ord_ready),
      .o_data  (w_ord_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   assign ord_valid = ~w_empty;
   assign ord_side  = w_ord_head.side;
   assign ord_qty   = w_ord_head.qty;
   assign ord_price = w_ord_head.price;
   assign position  = r_pos;
   assign pnl       = r_pnl;
   assign drop_cnt  = r_drop_cnt;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_order_manager.sv
// Bench for order_manager: reset checks, directed vector table, corner sequences, random vs. model.
`timescale 1ns/1ps
module tb_order_manager;

   localparam int QTY      = 1;
   localparam int DEPTH    = 4;
   localparam int PNL_W    = 48;
   localparam int COOLDOWN = 8;

   localparam logic [1:0] C_HOLD = 2'd0;
   localparam logic [1:0] C_BUY  = 2'd1;
   localparam logic [1:0] C_ILL  = 2'd2;
   localparam logic [1:0] C_SELL = 2'd3;

   localparam logic [31:0] P100 = 32'd6553600;
   localparam logic [31:0] P101 = 32'd6619136;
   localparam logic [31:0] P102 = 32'd6684672;
   localparam logic [31:0] P103 = 32'd6750208;
   localparam logic [31:0] P104 = 32'd6815744;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    sig_valid = 1'b0;
   logic [1:0]              sig_code = 2'd0;
   logic [31:0]             sig_price = 32'd0;
   logic                    ord_ready = 1'b0;
   logic                    ord_valid;
   logic                    ord_side;
   logic [8:0]              ord_qty;
   logic [31:0]             ord_price;
   logic [1:0]              position;
   logic [PNL_W-1:0]        pnl;
   logic [15:0]             drop_cnt;
   logic [15:0]             err_cnt;
   logic [$clog2(DEPTH):0]  fifo_level;

   order_manager #(
      .QTY(QTY), .DEPTH(DEPTH), .PNL_W(PNL_W), .COOLDOWN(COOLDOWN)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .sig_valid(sig_valid), .sig_code(sig_code), .sig_price(sig_price),
      .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_side(ord_side),
      .ord_qty(ord_qty), .ord_price(ord_price), .position(position),
      .pnl(pnl), .drop_cnt(drop_cnt), .err_cnt(err_cnt), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change 1ns after an edge; outputs are sampled 1ns after the next edge.
   task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] p, input logic r);
      sig_valid = v;
      sig_code  = c;
      sig_price = p;
      ord_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      sig_valid = 1'b0;
      sig_code  = C_HOLD;
      ord_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        v;
      logic [1:0]  code;
      logic [31:0] price;
      logic        rdy;
      logic        e_valid;
      logic        e_side;
      int          e_qty;
      logic [31:0] e_price;
      logic [1:0]  e_pos;
      longint      e_pnl;
      int          e_err;
      int          e_drop;
      int          e_level;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [31:0] p, input logic r,
                               input logic ev, input logic es, input int eq, input logic [31:0] ep,
                               input logic [1:0] epos, input longint epnl, input int eerr,
                               input int edrop, input int elev);
      vec_t t;
      t.v = v; t.code = c; t.price = p; t.rdy = r;
      t.e_valid = ev; t.e_side = es; t.e_qty = eq; t.e_price = ep; t.e_pos = epos;
      t.e_pnl = epnl; t.e_err = eerr; t.e_drop = edrop; t.e_level = elev;
      return t;
   endfunction

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic        side;
      int          qty;
      logic [31:0] price;
   } m_ord_t;

   m_ord_t m_q[$];
   int     m_pos;      // -1 short, 0 flat, +1 long
   longint m_entry;
   longint m_pnl;
   int     m_drop;
   int     m_err;
   int     m_cool;

   task automatic model_reset();
      m_q.delete();
      m_pos = 0; m_entry = 0; m_pnl = 0; m_drop = 0; m_err = 0; m_cool = 0;
   endtask

   task automatic model_step(input logic v, input logic [1:0] c, input logic [31:0] p, input logic r);
      bit     was_full;
      bit     popping;
      bit     accepted;
      bit     blocked;
      int     tgt;
      m_ord_t o;
      was_full = (m_q.size() == DEPTH);
      popping  = r && (m_q.size() > 0);
      accepted = 0;
      blocked  = 0;
`ifdef ORDER_COOLDOWN_EN
      blocked = (m_cool > 0);
`endif
      if (v && c == C_ILL && m_err < 65535)
         m_err++;
      if (v && (c == C_BUY || c == C_SELL) && !blocked) begin
         tgt = (c == C_BUY) ? 1 : -1;
         if (tgt != m_pos) begin
            if (was_full) begin
               if (m_drop < 65535) m_drop++;
            end else begin
               o.side  = (tgt < 0);
               o.qty   = ((tgt > m_pos) ? (tgt - m_pos) : (m_pos - tgt)) * QTY;
               o.price = p;
               if (m_pos != 0)
                  m_pnl += (longint'(p) - m_entry) * longint'(m_pos) * longint'(QTY);
               m_pos    = tgt;
               m_entry  = longint'(p);
               accepted = 1;
            end
         end
      end
`ifdef ORDER_COOLDOWN_EN
      if (accepted) m_cool = COOLDOWN;
      else if (m_cool > 0) m_cool--;
`endif
      if (popping) begin
         $display("[TB] order out side=%0d qty=%0d price=%0d", m_q[0].side, m_q[0].qty, m_q[0].price);
         void'(m_q.pop_front());
      end
      if (accepted)
         m_q.push_back(o);
   endtask

   task automatic model_compare(input int cyc);
      logic [63:0] pnl_exp;
      logic [1:0]  pos_exp;
      pnl_exp = 64'(m_pnl[PNL_W-1:0]);
      pos_exp = (m_pos == 0) ? 2'd0 : (m_pos > 0) ? 2'd1 : 2'd3;
      check($sformatf("rnd%0d.valid", cyc), ord_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         check($sformatf("rnd%0d.side", cyc), ord_side, m_q[0].side);
         check($sformatf("rnd%0d.qty", cyc), ord_qty, m_q[0].qty);
         check($sformatf("rnd%0d.price", cyc), ord_price, m_q[0].price);
      end
      check($sformatf("rnd%0d.pos", cyc), position, pos_exp);
      check($sformatf("rnd%0d.pnl", cyc), pnl, pnl_exp);
      check($sformatf("rnd%0d.drop", cyc), drop_cnt, m_drop);
      check($sformatf("rnd%0d.err", cyc), err_cnt, m_err);
      check($sformatf("rnd%0d.level", cyc), fifo_level, m_q.size());
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        rv;
      logic [1:0]  rc;
      logic        rr;
      logic [31:0] rp;
      int          sel;

      // ---- reset held with activity on the inputs ----
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sig_valid = (i % 2 == 0);
         sig_code  = C_BUY;
         sig_price = P100;
         ord_ready = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("rst%0d.valid", i), ord_valid, 0);
         check($sformatf("rst%0d.outs", i), {ord_side, ord_qty, ord_price}, 0);
         check($sformatf("rst%0d.pos", i), position, 0);
         check($sformatf("rst%0d.pnl", i), pnl, 0);
         check($sformatf("rst%0d.cnts", i), {drop_cnt, err_cnt}, 0);
         check($sformatf("rst%0d.level", i), fifo_level, 0);
      end
      $display("[TB] reset hold checked");

`ifndef ORDER_COOLDOWN_EN
      // ---- directed vector table ----
      vecs[0]  = mk(1, C_BUY,  P100, 1,  1, 0, 1, P100, 1, 0,      0, 0, 1);
      vecs[1]  = mk(1, C_SELL, P102, 1,  1, 1, 2, P102, 3, 131072, 0, 0, 1);
      vecs[2]  = mk(1, C_BUY,  P101, 1,  1, 0, 2, P101, 1, 196608, 0, 0, 1);
      vecs[3]  = mk(1, C_BUY,  P101, 1,  0, 0, 0, 0,    1, 196608, 0, 0, 0);
      vecs[4]  = mk(1, C_BUY,  P104, 1,  0, 0, 0, 0,    1, 196608, 0, 0, 0);
      vecs[5]  = mk(1, C_BUY,  P103, 1,  0, 0, 0, 0,    1, 196608, 0, 0, 0);
      vecs[6]  = mk(1, C_ILL,  P100, 1,  0, 0, 0, 0,    1, 196608, 1, 0, 0);
      vecs[7]  = mk(1, C_ILL,  P102, 1,  0, 0, 0, 0,    1, 196608, 2, 0, 0);
      vecs[8]  = mk(1, C_HOLD, P102, 1,  0, 0, 0, 0,    1, 196608, 2, 0, 0);
      vecs[9]  = mk(1, C_SELL, P100, 0,  1, 1, 2, P100, 3, 131072, 2, 0, 1);
      vecs[10] = mk(1, C_BUY,  P101, 0,  1, 1, 2, P100, 1, 65536,  2, 0, 2);
      vecs[11] = mk(1, C_SELL, P102, 0,  1, 1, 2, P100, 3, 131072, 2, 0, 3);
      vecs[12] = mk(1, C_BUY,  P103, 0,  1, 1, 2, P100, 1, 65536,  2, 0, 4);
      vecs[13] = mk(1, C_SELL, P104, 0,  1, 1, 2, P100, 1, 65536,  2, 1, 4);
      vecs[14] = mk(1, C_SELL, P104, 1,  1, 0, 2, P101, 1, 65536,  2, 2, 3);
      vecs[15] = mk(1, C_HOLD, P104, 1,  1, 1, 2, P102, 1, 65536,  2, 2, 2);
      vecs[16] = mk(0, C_HOLD, P104, 1,  1, 0, 2, P103, 1, 65536,  2, 2, 1);
      vecs[17] = mk(1, C_HOLD, P104, 1,  0, 0, 0, 0,    1, 65536,  2, 2, 0);

      do_reset();
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].v, vecs[i].code, vecs[i].price, vecs[i].rdy);
         check($sformatf("v%0d.valid", i), ord_valid, vecs[i].e_valid);
         check($sformatf("v%0d.side", i), ord_side, vecs[i].e_side);
         check($sformatf("v%0d.qty", i), ord_qty, vecs[i].e_qty);
         check($sformatf("v%0d.price", i), ord_price, vecs[i].e_price);
         check($sformatf("v%0d.pos", i), position, vecs[i].e_pos);
         check($sformatf("v%0d.pnl", i), pnl, 64'(vecs[i].e_pnl));
         check($sformatf("v%0d.err", i), err_cnt, vecs[i].e_err);
         check($sformatf("v%0d.drop", i), drop_cnt, vecs[i].e_drop);
         check($sformatf("v%0d.level", i), fifo_level, vecs[i].e_level);
         $display("[TB] vec %0d code=%0d rdy=%0d -> valid=%0d qty=%0d pos=%0d lvl=%0d",
                  i, vecs[i].code, vecs[i].rdy, ord_valid, ord_qty, position, fifo_level);
      end
`endif

      // ---- asynchronous reset with orders queued ----
      do_reset();
      drive(1, C_BUY,  P100, 0);
      drive(1, C_SELL, P101, 0);
      drive(1, C_BUY,  P102, 0);
`ifdef ORDER_COOLDOWN_EN
      check("midrst.level_before", fifo_level, 1);
`else
      check("midrst.level_before", fifo_level, 3);
`endif
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst.valid", ord_valid, 0);
      check("midrst.level", fifo_level, 0);
      check("midrst.pos", position, 0);
      check("midrst.pnl", pnl, 0);
      $display("[TB] mid-run reset checked");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ---- cooldown window sequence (BUY t, SELL t+3, SELL t+10) ----
      do_reset();
      drive(1, C_BUY, P100, 1);
      check("cool.t0.pos", position, 1);
      drive(1, C_HOLD, P100, 1);
      drive(1, C_HOLD, P100, 1);
      drive(1, C_SELL, P101, 1);
`ifdef ORDER_COOLDOWN_EN
      check("cool.t3.pos", position, 1);
      check("cool.t3.valid", ord_valid, 0);
`else
      check("cool.t3.pos", position, 3);
      check("cool.t3.valid", ord_valid, 1);
`endif
      for (int i = 4; i < 10; i++)
         drive(1, C_HOLD, P101, 1);
      drive(1, C_SELL, P102, 1);
`ifdef ORDER_COOLDOWN_EN
      check("cool.t10.pos", position, 3);
      check("cool.t10.valid", ord_valid, 1);
      check("cool.t10.qty", ord_qty, 2);
`else
      check("cool.t10.pos", position, 3);
      check("cool.t10.valid", ord_valid, 0);
`endif
      check("cool.drop", drop_cnt, 0);
      $display("[TB] cooldown sequence checked");

      // ---- randomized run against the reference model ----
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         rv  = ($urandom_range(0, 9) != 0);
         sel = $urandom_range(0, 9);
         rc  = (sel < 4) ? C_BUY : (sel < 8) ? C_SELL : (sel == 8) ? C_HOLD : C_ILL;
         rp  = $urandom;
         rr  = ($urandom_range(0, 2) != 0);
         model_step(rv, rc, rp, rr);
         drive(rv, rc, rp, rr);
         model_compare(cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
